// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: RV32I decode stage with integrated register file,
// writeback bypass, valid/ready handshake, flush and load-use stall.
// The decode output register is the ID/EX pipeline register.
//
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN
//   defined   -> unknown opcodes / out-of-range register indices set
//                cntrl_sig_decode[9]; extra port illegal_instr_decode mirrors it
//   undefined -> cntrl_sig_decode[9] is always 0, no illegal_instr_decode port
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   fetch_valid/fetch_ready     fetch handshake (fetch_ready is combinational)
//   instr_reg_fetch, pc_fetch, npc_fetch   fetch payload
//   flush                       drop held instruction and fetch input
//   wb_en, wb_rd, wb_data       register file write port
//   exec_ready                  execute consumes the output register
//   decode_valid, *_decode, operand_a/b    ID/EX register outputs
module decode_stage_pipe #(
  parameter int unsigned data_width     = 32,
  parameter int unsigned NUM_REGS       = 32,
  parameter int unsigned CTRL_WIDTH     = 32,
  parameter int unsigned ALU_CTRL_WIDTH = 4,
  localparam int unsigned RW            = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fetch_valid,
  output logic                      fetch_ready,
  input  logic [31:0]               instr_reg_fetch,
  input  logic [data_width-1:0]     pc_fetch,
  input  logic [data_width-1:0]     npc_fetch,
  input  logic                      flush,
  input  logic                      wb_en,
  input  logic [RW-1:0]             wb_rd,
  input  logic [data_width-1:0]     wb_data,
  input  logic                      exec_ready,
  output logic                      decode_valid,
  output logic [31:0]               instr_reg_decode,
  output logic [data_width-1:0]     pc_decode,
  output logic [data_width-1:0]     npc_decode,
  output logic [CTRL_WIDTH-1:0]     cntrl_sig_decode,
  output logic [ALU_CTRL_WIDTH-1:0] alu_control_decode,
  output logic [data_width-1:0]     imm_data_decode,
  output logic [data_width-1:0]     operand_a,
  output logic [data_width-1:0]     operand_b,
  output logic [RW-1:0]             rs1_decode,
  output logic [RW-1:0]             rs2_decode,
  output logic [RW-1:0]             rd_decode
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic                      illegal_instr_decode
`endif
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2,
                         ALU_SLT = 4'd3, ALU_SLTU = 4'd4, ALU_XOR = 4'd5,
                         ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8,
                         ALU_AND = 4'd9;

  // ALU op from funct3/funct7[5]; SUB only exists for register-register ops
  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic f7b5,
                                         input logic is_reg);
    case (f3)
      3'b000:  alu_sel = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_sel = ALU_SLL;
      3'b010:  alu_sel = ALU_SLT;
      3'b011:  alu_sel = ALU_SLTU;
      3'b100:  alu_sel = ALU_XOR;
      3'b101:  alu_sel = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_sel = ALU_OR;
      default: alu_sel = ALU_AND;
    endcase
  endfunction

  logic [data_width-1:0] rf_q [NUM_REGS];

  logic                      valid_q, valid_d;
  logic [31:0]               instr_q, instr_d;
  logic [data_width-1:0]     pc_q, pc_d, npc_q, npc_d;
  logic [CTRL_WIDTH-1:0]     ctrl_q, ctrl_d;
  logic [ALU_CTRL_WIDTH-1:0] alu_q, alu_d;
  logic [data_width-1:0]     imm_q, imm_d, opa_q, opa_d, opb_q, opb_d;
  logic [RW-1:0]             rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;

  logic [6:0]  opc;
  logic [4:0]  rs1_f, rs2_f, rd_f;
  logic [9:0]  ctrl10;
  logic [3:0]  alu4;
  logic [31:0] imm32;
  logic        rs1_used, rs2_used, unknown;
  logic        hazard, accept;
  logic [data_width-1:0] rs1_val, rs2_val;

  assign opc   = instr_reg_fetch[6:0];
  assign rd_f  = instr_reg_fetch[11:7];
  assign rs1_f = instr_reg_fetch[19:15];
  assign rs2_f = instr_reg_fetch[24:20];

  // Instruction decode: control bundle, ALU op, immediate, source usage
  always_comb begin
    ctrl10   = '0;
    alu4     = ALU_ADD;
    imm32    = '0;
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    unknown  = 1'b0;
    case (opc)
      OPC_OP: begin
        ctrl10[0] = 1'b1;
        rs2_used  = 1'b1;
        alu4      = alu_sel(instr_reg_fetch[14:12], instr_reg_fetch[30], 1'b1);
      end
      OPC_OPIMM: begin
        ctrl10[0] = 1'b1;
        ctrl10[6] = 1'b1;
        alu4      = alu_sel(instr_reg_fetch[14:12], instr_reg_fetch[30], 1'b0);
        imm32     = {{20{instr_reg_fetch[31]}}, instr_reg_fetch[31:20]};
      end
      OPC_LOAD: begin
        ctrl10[0] = 1'b1;
        ctrl10[1] = 1'b1;
        ctrl10[6] = 1'b1;
        imm32     = {{20{instr_reg_fetch[31]}}, instr_reg_fetch[31:20]};
      end
      OPC_STORE: begin
        ctrl10[2] = 1'b1;
        ctrl10[6] = 1'b1;
        rs2_used  = 1'b1;
        imm32     = {{20{instr_reg_fetch[31]}}, instr_reg_fetch[31:25],
                     instr_reg_fetch[11:7]};
      end
      OPC_BRANCH: begin
        ctrl10[3] = 1'b1;
        rs2_used  = 1'b1;
        alu4      = ALU_SUB;
        imm32     = {{19{instr_reg_fetch[31]}}, instr_reg_fetch[31], instr_reg_fetch[7],
                     instr_reg_fetch[30:25], instr_reg_fetch[11:8], 1'b0};
      end
      OPC_JAL: begin
        ctrl10[0] = 1'b1;
        ctrl10[4] = 1'b1;
        rs1_used  = 1'b0;
        imm32     = {{11{instr_reg_fetch[31]}}, instr_reg_fetch[31], instr_reg_fetch[19:12],
                     instr_reg_fetch[20], instr_reg_fetch[30:21], 1'b0};
      end
      OPC_JALR: begin
        ctrl10[0] = 1'b1;
        ctrl10[5] = 1'b1;
        ctrl10[6] = 1'b1;
        imm32     = {{20{instr_reg_fetch[31]}}, instr_reg_fetch[31:20]};
      end
      OPC_LUI: begin
        ctrl10[0] = 1'b1;
        ctrl10[6] = 1'b1;
        ctrl10[7] = 1'b1;
        rs1_used  = 1'b0;
        imm32     = {instr_reg_fetch[31:12], 12'h000};
      end
      OPC_AUIPC: begin
        ctrl10[0] = 1'b1;
        ctrl10[6] = 1'b1;
        ctrl10[8] = 1'b1;
        rs1_used  = 1'b0;
        imm32     = {instr_reg_fetch[31:12], 12'h000};
      end
      default: unknown = 1'b1;
    endcase
`ifdef DECODE_ILLEGAL_TRAP_EN
    // Out-of-range indices only matter for fields the format actually uses
    if (unknown
        || (rs1_used && (32'(rs1_f) >= NUM_REGS))
        || (rs2_used && (32'(rs2_f) >= NUM_REGS))
        || (opc != OPC_STORE && opc != OPC_BRANCH && (32'(rd_f) >= NUM_REGS)))
      ctrl10[9] = 1'b1;
`else
    ctrl10[9] = 1'b0;
`endif
  end

  // Register read with writeback bypass; x0 and out-of-range indices read 0
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1_f != 5'd0 && 32'(rs1_f) < NUM_REGS)
      rs1_val = (wb_en && 5'(wb_rd) == rs1_f) ? wb_data : rf_q[rs1_f[RW-1:0]];
    if (rs2_f != 5'd0 && 32'(rs2_f) < NUM_REGS)
      rs2_val = (wb_en && 5'(wb_rd) == rs2_f) ? wb_data : rf_q[rs2_f[RW-1:0]];
  end

  // Load-use hazard: held load writes a register the fetched instruction reads
  assign hazard = valid_q && ctrl_q[1] && (rd_q != '0)
               && ((rs1_used && rs1_f == 5'(rd_q)) || (rs2_used && rs2_f == 5'(rd_q)));
  assign fetch_ready = (!valid_q || exec_ready) && !hazard && !flush;
  assign accept      = fetch_valid && fetch_ready;

  // ID/EX next state: flush > accept > bubble > hold
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    ctrl_d  = ctrl_q;
    alu_d   = alu_q;
    imm_d   = imm_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      instr_d = instr_reg_fetch;
      pc_d    = pc_fetch;
      npc_d   = npc_fetch;
      ctrl_d  = CTRL_WIDTH'(ctrl10);
      alu_d   = ALU_CTRL_WIDTH'(alu4);
      imm_d   = data_width'($signed(imm32));
      opa_d   = rs1_val;
      opb_d   = rs2_val;
      rs1_d   = rs1_f[RW-1:0];
      rs2_d   = rs2_f[RW-1:0];
      rd_d    = rd_f[RW-1:0];
    end else if (exec_ready) begin
      valid_d = 1'b0;
    end
  end

  // ID/EX register
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
      npc_q   <= '0;
      ctrl_q  <= '0;
      alu_q   <= '0;
      imm_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      ctrl_q  <= ctrl_d;
      alu_q   <= alu_d;
      imm_q   <= imm_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
    end
  end

  // Register file; writes proceed regardless of stall/flush
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) rf_q[i] <= '0;
    end else if (wb_en && wb_rd != '0 && 32'(wb_rd) < NUM_REGS) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  assign decode_valid       = valid_q;
  assign instr_reg_decode   = instr_q;
  assign pc_decode          = pc_q;
  assign npc_decode         = npc_q;
  assign cntrl_sig_decode   = ctrl_q;
  assign alu_control_decode = alu_q;
  assign imm_data_decode    = imm_q;
  assign operand_a          = opa_q;
  assign operand_b          = opb_q;
  assign rs1_decode         = rs1_q;
  assign rs2_decode         = rs2_q;
  assign rd_decode          = rd_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign illegal_instr_decode = ctrl_q[9];
`endif

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed self-checking bench for decode_stage_pipe (default parameters).
module tb_decode_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid, fetch_ready;
  logic [31:0] instr_reg_fetch, pc_fetch, npc_fetch;
  logic        flush, wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exec_ready, decode_valid;
  logic [31:0] instr_reg_decode, pc_decode, npc_decode, cntrl_sig_decode;
  logic [3:0]  alu_control_decode;
  logic [31:0] imm_data_decode, operand_a, operand_b;
  logic [4:0]  rs1_decode, rs2_decode, rd_decode;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic        illegal_instr_decode;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_stage_pipe dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .instr_reg_fetch(instr_reg_fetch), .pc_fetch(pc_fetch), .npc_fetch(npc_fetch),
    .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .exec_ready(exec_ready), .decode_valid(decode_valid),
    .instr_reg_decode(instr_reg_decode), .pc_decode(pc_decode), .npc_decode(npc_decode),
    .cntrl_sig_decode(cntrl_sig_decode), .alu_control_decode(alu_control_decode),
    .imm_data_decode(imm_data_decode), .operand_a(operand_a), .operand_b(operand_b),
    .rs1_decode(rs1_decode), .rs2_decode(rs2_decode), .rd_decode(rd_decode)
`ifdef DECODE_ILLEGAL_TRAP_EN
    , .illegal_instr_decode(illegal_instr_decode)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; land 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] ins, input logic [31:0] pc);
    fetch_valid     = 1'b1;
    instr_reg_fetch = ins;
    pc_fetch        = pc;
    npc_fetch       = pc + 32'd4;
  endtask

  initial begin
    rst = 1'b1; fetch_valid = 1'b0; instr_reg_fetch = '0; pc_fetch = '0; npc_fetch = '0;
    flush = 1'b0; wb_en = 1'b0; wb_rd = '0; wb_data = '0; exec_ready = 1'b1;

    // Reset
    step(); step();
    chk("rst_valid", 64'(decode_valid), 64'd0);
    chk("rst_ctrl",  64'(cntrl_sig_decode), 64'd0);
    chk("rst_opa",   64'(operand_a), 64'd0);
    chk("rst_pc",    64'(pc_decode), 64'd0);
    chk("rst_imm",   64'(imm_data_decode), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_fetch_ready", 64'(fetch_ready), 64'd1);

    // Register writes x5, x6
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h11111111;
    step();
    wb_rd = 5'd6; wb_data = 32'h22222222;
    step();
    wb_en = 1'b0;

    // ADD x3,x5,x6
    fetch(32'h006281B3, 32'hABCDEF01);
    step();
    chk("add_valid", 64'(decode_valid), 64'd1);
    chk("add_opa",   64'(operand_a), 64'h11111111);
    chk("add_opb",   64'(operand_b), 64'h22222222);
    chk("add_alu",   64'(alu_control_decode), 64'd0);
    chk("add_ctrl",  64'(cntrl_sig_decode), 64'h1);
    chk("add_rd",    64'(rd_decode), 64'd3);
    chk("add_pc",    64'(pc_decode), 64'hABCDEF01);
    chk("add_npc",   64'(npc_decode), 64'hABCDEF05);
    chk("add_imm",   64'(imm_data_decode), 64'd0);

    // Bypass: ADDI x8,x7,-1 while x7 is being written
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h0000ABCD;
    fetch(32'hFFF38413, 32'h00000100);
    step();
    wb_en = 1'b0;
    chk("byp_opa",  64'(operand_a), 64'h0000ABCD);
    chk("byp_imm",  64'(imm_data_decode), 64'hFFFFFFFF);
    chk("byp_ctrl", 64'(cntrl_sig_decode), 64'h41);
    chk("byp_rd",   64'(rd_decode), 64'd8);

    // Load-use: LW x5,0(x1) then ADD x6,x5,x0
    fetch(32'h0000A283, 32'h00000104);
    step();
    chk("lw_ctrl", 64'(cntrl_sig_decode), 64'h43);
    chk("lw_rd",   64'(rd_decode), 64'd5);
    fetch(32'h00028333, 32'h00000108);
    #1;
    chk("lu_stall_ready", 64'(fetch_ready), 64'd0);
    step();
    chk("lu_bubble", 64'(decode_valid), 64'd0);
    chk("lu_ready_again", 64'(fetch_ready), 64'd1);
    step();
    chk("lu_add_valid", 64'(decode_valid), 64'd1);
    chk("lu_add_rd",    64'(rd_decode), 64'd6);
    chk("lu_add_opa",   64'(operand_a), 64'h11111111);
    chk("lu_add_pc",    64'(pc_decode), 64'h00000108);

    // Control case: LW then ADD x6,x0,x0 does not stall
    fetch(32'h0000A283, 32'h0000010C);
    step();
    fetch(32'h00000333, 32'h00000110);
    #1;
    chk("nolu_ready", 64'(fetch_ready), 64'd1);
    step();
    chk("nolu_valid", 64'(decode_valid), 64'd1);
    chk("nolu_pc",    64'(pc_decode), 64'h00000110);
    chk("nolu_opa",   64'(operand_a), 64'd0);

    // SW x7,8(x5)
    fetch(32'h0072A423, 32'h00000114);
    step();
    chk("sw_ctrl", 64'(cntrl_sig_decode), 64'h44);
    chk("sw_imm",  64'(imm_data_decode), 64'd8);
    chk("sw_opa",  64'(operand_a), 64'h11111111);
    chk("sw_opb",  64'(operand_b), 64'h0000ABCD);

    // Backpressure for 3 cycles with SUB x3,x5,x6 waiting
    exec_ready = 1'b0;
    fetch(32'h406281B3, 32'h00000200);
    #1;
    chk("bp_ready0", 64'(fetch_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_valid", 64'(decode_valid), 64'd1);
      chk("bp_ctrl",  64'(cntrl_sig_decode), 64'h44);
      chk("bp_imm",   64'(imm_data_decode), 64'd8);
      chk("bp_pc",    64'(pc_decode), 64'h00000114);
      chk("bp_opb",   64'(operand_b), 64'h0000ABCD);
      chk("bp_ready", 64'(fetch_ready), 64'd0);
    end
    exec_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(fetch_ready), 64'd1);
    step();
    chk("sub_alu",  64'(alu_control_decode), 64'd1);
    chk("sub_ctrl", 64'(cntrl_sig_decode), 64'h1);
    chk("sub_pc",   64'(pc_decode), 64'h00000200);

    // BEQ x5,x6,-4
    fetch(32'hFE628EE3, 32'h00000204);
    step();
    chk("beq_ctrl", 64'(cntrl_sig_decode), 64'h8);
    chk("beq_alu",  64'(alu_control_decode), 64'd1);
    chk("beq_imm",  64'(imm_data_decode), 64'hFFFFFFFC);
    chk("beq_opb",  64'(operand_b), 64'h22222222);

    // LUI x10,0x12345
    fetch(32'h12345537, 32'h00000208);
    step();
    chk("lui_imm", 64'(imm_data_decode), 64'h12345000);
    chk("lui_bit", 64'(cntrl_sig_decode[7]), 64'd1);
    chk("lui_rd",  64'(rd_decode), 64'd10);

    // Unknown opcode behaves as NOP
    fetch(32'h0000000B, 32'h0000020C);
    step();
    chk("unk_valid", 64'(decode_valid), 64'd1);
    chk("unk_ctrl_lo", 64'(cntrl_sig_decode[8:0]), 64'd0);
    chk("unk_imm",   64'(imm_data_decode), 64'd0);

    // Flush with a pending fetch and a concurrent writeback to x9
    fetch(32'h12345537, 32'h00000300);
    flush = 1'b1;
    wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'd5;
    #1;
    chk("fl_ready", 64'(fetch_ready), 64'd0);
    step();
    chk("fl_valid", 64'(decode_valid), 64'd0);
    flush = 1'b0; wb_en = 1'b0; fetch_valid = 1'b0;
    step();
    chk("fl_dropped", 64'(decode_valid), 64'd0);
    chk("fl_pc_not_loaded", 64'(pc_decode), 64'h0000020C);

    // ADD x11,x9,x0 reads the value written during flush
    fetch(32'h000485B3, 32'h00000304);
    step();
    fetch_valid = 1'b0;
    chk("x9_valid", 64'(decode_valid), 64'd1);
    chk("x9_opa",   64'(operand_a), 64'd5);
    chk("x9_rd",    64'(rd_decode), 64'd11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
